// File: rtl/intersection_phase_ctrl.sv
// rtl/intersection_phase_ctrl.sv - two-way intersection phase sequencer with pedestrian walk service
module intersection_phase_ctrl #(
  parameter int TICK_DIV      = 50000000,
  parameter int GRN_TICKS     = 20,
  parameter int MIN_GRN_TICKS = 10,
  parameter int YLW_TICKS     = 4,
  parameter int ALLRED_TICKS  = 2,
  parameter int WALK_TICKS    = 7
) (
  input  logic       clk_50_mhz,
  input  logic       reset_n,
  input  logic       nrth_pedo_button,
  input  logic       west_pedo_button,
  output logic       red_nrth,
  output logic       ylw_nrth,
  output logic       grn_nrth,
  output logic       red_west,
  output logic       ylw_west,
  output logic       grn_west,
  output logic       walk_nrth,
  output logic       stop_nrth,
  output logic       walk_west,
  output logic       stop_west,
  output logic       nrth_ped_q,
  output logic       west_ped_q,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    RED_TO_NS = 3'd0,
    NS_GRN    = 3'd1,
    NS_YLW    = 3'd2,
    RED_TO_EW = 3'd3,
    EW_GRN    = 3'd4,
    EW_YLW    = 3'd5
  } state_t;

  // Timer never exceeds the longest duration minus one, since it clears on every state change.
  localparam int MAXT0 = (GRN_TICKS > YLW_TICKS) ? GRN_TICKS : YLW_TICKS;
  localparam int MAXT  = (MAXT0 > ALLRED_TICKS) ? MAXT0 : ALLRED_TICKS;
  localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int PW    = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PRESC_END   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GRN_END     = TW'(GRN_TICKS - 1);
  localparam logic [TW-1:0] MIN_GRN_END = TW'(MIN_GRN_TICKS - 1);
  localparam logic [TW-1:0] YLW_END     = TW'(YLW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_END  = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_END    = TW'(WALK_TICKS - 1);

  state_t        r_state, w_next, w_seq;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_timer, w_dur_end;
  logic          r_nrth_s1, r_nrth_s2, r_nrth_prev, r_west_s1, r_west_s2, r_west_prev;
  logic          r_nrth_q, r_west_q;
  logic [2:0]    r_lamp_n, r_lamp_w;
  logic          r_walk_n, r_stop_n, r_walk_w, r_stop_w;
  logic          w_tick, w_nrth_evt, w_west_evt, w_gap, w_legal;
  logic          w_ns_entry, w_ew_entry, w_walk_n_nxt, w_walk_w_nxt;

  assign {red_nrth, ylw_nrth, grn_nrth} = r_lamp_n;
  assign {red_west, ylw_west, grn_west} = r_lamp_w;
  assign walk_nrth  = r_walk_n;
  assign stop_nrth  = r_stop_n;
  assign walk_west  = r_walk_w;
  assign stop_west  = r_stop_w;
  assign nrth_ped_q = r_nrth_q;
  assign west_ped_q = r_west_q;
  assign phase      = r_state;

  always_comb begin
    w_tick     = (r_presc == PRESC_END);
    w_nrth_evt = ~r_nrth_s2 & r_nrth_prev;
    w_west_evt = ~r_west_s2 & r_west_prev;
    w_legal    = 1'b1;
    w_seq      = RED_TO_NS;
    w_dur_end  = ALLRED_END;
    w_gap      = 1'b0;
    case (r_state)
      RED_TO_NS: w_seq = NS_GRN;
      NS_GRN: begin
        w_seq     = NS_YLW;
        w_dur_end = GRN_END;
        w_gap     = r_west_q && (r_timer >= MIN_GRN_END);
      end
      NS_YLW: begin
        w_seq     = RED_TO_EW;
        w_dur_end = YLW_END;
      end
      RED_TO_EW: w_seq = EW_GRN;
      EW_GRN: begin
        w_seq     = EW_YLW;
        w_dur_end = GRN_END;
        w_gap     = r_nrth_q && (r_timer >= MIN_GRN_END);
      end
      EW_YLW: begin
        w_seq     = RED_TO_NS;
        w_dur_end = YLW_END;
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal)
      w_next = RED_TO_NS;
    else if (w_tick && ((r_timer == w_dur_end) || w_gap))
      w_next = w_seq;
    else
      w_next = r_state;

    w_ns_entry = (r_state == RED_TO_NS) && (w_next == NS_GRN);
    w_ew_entry = (r_state == RED_TO_EW) && (w_next == EW_GRN);

    // A press detected on the entry edge itself is served by this green.
    w_walk_n_nxt = r_walk_n;
    if (w_ns_entry)
      w_walk_n_nxt = r_nrth_q | w_nrth_evt;
    else if ((w_next != NS_GRN) || (w_tick && (r_timer == WALK_END)))
      w_walk_n_nxt = 1'b0;

    w_walk_w_nxt = r_walk_w;
    if (w_ew_entry)
      w_walk_w_nxt = r_west_q | w_west_evt;
    else if ((w_next != EW_GRN) || (w_tick && (r_timer == WALK_END)))
      w_walk_w_nxt = 1'b0;
  end

  always_ff @(posedge clk_50_mhz) begin
    if (!reset_n) begin
      r_state     <= RED_TO_NS;
      r_presc     <= '0;
      r_timer     <= '0;
      r_nrth_s1   <= 1'b1;
      r_nrth_s2   <= 1'b1;
      r_nrth_prev <= 1'b1;
      r_west_s1   <= 1'b1;
      r_west_s2   <= 1'b1;
      r_west_prev <= 1'b1;
      r_nrth_q    <= 1'b0;
      r_west_q    <= 1'b0;
      r_lamp_n    <= 3'b100;
      r_lamp_w    <= 3'b100;
      r_walk_n    <= 1'b0;
      r_stop_n    <= 1'b1;
      r_walk_w    <= 1'b0;
      r_stop_w    <= 1'b1;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      r_nrth_s1   <= nrth_pedo_button;
      r_nrth_s2   <= r_nrth_s1;
      r_nrth_prev <= r_nrth_s2;
      r_west_s1   <= west_pedo_button;
      r_west_s2   <= r_west_s1;
      r_west_prev <= r_west_s2;
      r_state     <= w_next;

      if (w_next != r_state)
        r_timer <= '0;
      else if (w_tick)
        r_timer <= r_timer + 1'b1;

      if (w_ns_entry)
        r_nrth_q <= 1'b0;
      else if (w_nrth_evt)
        r_nrth_q <= 1'b1;

      if (w_ew_entry)
        r_west_q <= 1'b0;
      else if (w_west_evt)
        r_west_q <= 1'b1;

      r_walk_n <= w_walk_n_nxt;
      r_stop_n <= ~w_walk_n_nxt;
      r_walk_w <= w_walk_w_nxt;
      r_stop_w <= ~w_walk_w_nxt;
      r_lamp_n <= {(w_next != NS_GRN) && (w_next != NS_YLW), w_next == NS_YLW, w_next == NS_GRN};
      r_lamp_w <= {(w_next != EW_GRN) && (w_next != EW_YLW), w_next == EW_YLW, w_next == EW_GRN};
    end
  end

endmodule
